// File: rtl/limiter_duty_sched_pkg.sv
// Shared constants for the limiter duty-cycle scheduler: register map, CTRL bits, state codes.
// The firmware driver header mirrors these values.
package limiter_duty_sched_pkg;

    localparam logic [2:0] LIMITER_SCHED_CTRL    = 3'd0;
    localparam logic [2:0] LIMITER_SCHED_SETTLE  = 3'd1;
    localparam logic [2:0] LIMITER_SCHED_ON      = 3'd2;
    localparam logic [2:0] LIMITER_SCHED_OFF     = 3'd3;
    localparam logic [2:0] LIMITER_SCHED_STATUS  = 3'd4;
    localparam logic [2:0] LIMITER_SCHED_WIN_CNT = 3'd5;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_ONESHOT_BIT = 1;
    localparam int CTRL_IRQ_CLR_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_SLEEP  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/limiter_duty_sched_timer.sv
// Loadable down-counter that times one scheduler window; done is high while the count is zero.
module limiter_sched_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/limiter_duty_sched.sv
// RF limiter duty-cycle scheduler: CPU register file plus settle/active/sleep sequencer.
// Optional early wake from SLEEP via ext_wake when LIMITER_SCHED_WAKE_EN is defined.
//
// state  | meaning
// IDLE   | limiter off, waiting for EN
// SETTLE | limiter powered, output not yet trusted
// ACTIVE | limiter settled, demodulator receiving
// SLEEP  | limiter off between receive windows
module limiter_duty_sched #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [2:0]        address,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wstrb,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
`ifdef LIMITER_SCHED_WAKE_EN
    input  logic              ext_wake,
`endif
    output logic              pd,
    output logic              rx_en,
    output logic              irq
);
    import limiter_duty_sched_pkg::*;

    sched_state_e      state_q, state_d;
    logic              en_q, en_d, oneshot_q, oneshot_d, irq_q, irq_d;
    logic [CNT_W-1:0]  settle_q, settle_d, on_q, on_d, off_q, off_d;
    logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
    logic              pd_q, pd_d, rx_en_q, rx_en_d, ready_q;
    logic [DATA_W-1:0] rdata_q, rd_mux;
    logic [CNT_W-1:0]  win_len, tmr_load_val;
    logic              tmr_load, tmr_done, wr, win_end, wake;
    logic              unused_wdata_hi;

    assign unused_wdata_hi = ^wdata[DATA_W-1:CNT_W];
    assign wr      = valid && wstrb;
    assign win_end = (state_q == ST_ACTIVE) && tmr_done && en_q;

`ifdef LIMITER_SCHED_WAKE_EN
    assign wake = ext_wake;
`else
    assign wake = 1'b0;
`endif

    always_comb begin
        en_d      = en_q;
        oneshot_d = oneshot_q;
        settle_d  = settle_q;
        on_d      = on_q;
        off_d     = off_q;
        irq_d     = irq_q;
        win_cnt_d = win_cnt_q;
        if (wr) begin
            case (address)
                LIMITER_SCHED_CTRL: begin
                    en_d      = wdata[CTRL_EN_BIT];
                    oneshot_d = wdata[CTRL_ONESHOT_BIT];
                    if (wdata[CTRL_IRQ_CLR_BIT]) irq_d = 1'b0;
                end
                LIMITER_SCHED_SETTLE: settle_d = wdata[CNT_W-1:0];
                LIMITER_SCHED_ON:     on_d     = wdata[CNT_W-1:0];
                LIMITER_SCHED_OFF:    off_d    = wdata[CNT_W-1:0];
                default: ;
            endcase
        end
        // Window end overrides a coincident IRQ_CLR or CTRL write.
        if (win_end) begin
            irq_d     = 1'b1;
            win_cnt_d = win_cnt_q + CNT_W'(1);
            if (oneshot_q) en_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q      <= 1'b0;
            oneshot_q <= 1'b0;
            settle_q  <= '0;
            on_q      <= '0;
            off_q     <= '0;
            irq_q     <= 1'b0;
            win_cnt_q <= '0;
        end else begin
            en_q      <= en_d;
            oneshot_q <= oneshot_d;
            settle_q  <= settle_d;
            on_q      <= on_d;
            off_q     <= off_d;
            irq_q     <= irq_d;
            win_cnt_q <= win_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pd_q    <= 1'b1;
            rx_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pd_q    <= pd_d;
            rx_en_q <= rx_en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q != ST_IDLE && !en_q) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (en_q) state_d = ST_SETTLE;
                ST_SETTLE: if (tmr_done) state_d = ST_ACTIVE;
                ST_ACTIVE: if (tmr_done) state_d = oneshot_q ? ST_IDLE : ST_SLEEP;
                ST_SLEEP:  if (wake || tmr_done) state_d = ST_SETTLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pd_d    = (state_d == ST_IDLE) || (state_d == ST_SLEEP);
        rx_en_d = (state_d == ST_ACTIVE);
    end

    // Window length is sampled on entry, so mid-window writes apply next entry.
    always_comb begin
        case (state_d)
            ST_SETTLE: win_len = settle_q;
            ST_ACTIVE: win_len = on_q;
            ST_SLEEP:  win_len = off_q;
            default:   win_len = '0;
        endcase
        tmr_load     = (state_d != state_q);
        tmr_load_val = (win_len == '0) ? '0 : win_len - CNT_W'(1);
    end

    limiter_sched_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .done_o     (tmr_done)
    );

    always_comb begin
        rd_mux = '0;
        case (address)
            LIMITER_SCHED_CTRL: begin
                rd_mux[CTRL_EN_BIT]      = en_q;
                rd_mux[CTRL_ONESHOT_BIT] = oneshot_q;
            end
            LIMITER_SCHED_SETTLE:  rd_mux[CNT_W-1:0] = settle_q;
            LIMITER_SCHED_ON:      rd_mux[CNT_W-1:0] = on_q;
            LIMITER_SCHED_OFF:     rd_mux[CNT_W-1:0] = off_q;
            LIMITER_SCHED_STATUS: begin
                rd_mux[1:0] = state_q;
                rd_mux[2]   = irq_q;
            end
            LIMITER_SCHED_WIN_CNT: rd_mux[CNT_W-1:0] = win_cnt_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= valid;
            if (valid && !wstrb) rdata_q <= rd_mux;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign pd    = pd_q;
    assign rx_en = rx_en_q;
    assign irq   = irq_q;

endmodule

// File: doc/limiter_duty_sched.md
Name: limiter_duty_sched

Overview:
CPU-programmable duty-cycle scheduler for the RF limiter power-down line in the WSN energy-management SoC.
- Sequences the limiter through settle, active-receive and sleep windows without CPU intervention.
- Drives the limiter pd input and a settled/receive-enable strobe to the demodulator.
- Raises a sticky interrupt at the end of each receive window.
- Sits on the same simple CPU bus (valid/address/wdata/wstrb/ready) as other peripherals.

Parameters:
DATA_W, 32, CPU data width
CNT_W, 16, width of window/settle counters and window count

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
valid  input  1  CPU access request
address  input  3  register select
wdata  input  DATA_W  write data
wstrb  input  1  1=write, 0=read
rdata  output  DATA_W  read data, registered
ready  output  1  access done, registered
ext_wake  input  1  early wake request (only with LIMITER_SCHED_WAKE_EN)
pd  output  1  limiter power-down, 1=off
rx_en  output  1  limiter powered and settled
irq  output  1  sticky end-of-window interrupt

Behaviour:
Reset and interface:
- Reset is asynchronous, active-high, on rst; clock is clk.
- Reset values: pd=1, rx_en=0, irq=0, ready=0, rdata=0, state=IDLE, all registers 0.
- ready <= valid every cycle (1-cycle latency). Writes commit on the valid cycle. rdata is loaded on the valid cycle for reads and holds otherwise.

Registers (address):
- 0 CTRL: bit0 EN, bit1 ONESHOT, bit2 IRQ_CLR (write-only, self-clearing).
- 1 SETTLE_CYC.
- 2 ON_CYC.
- 3 OFF_CYC.
- 4 STATUS, read-only: bits[1:0] state, bit2 irq.
- 5 WIN_CNT, read-only: completed active windows, CNT_W bits, wraps to 0 after all-ones.
- 6-7: reads return 0, writes ignored.
- Only the low CNT_W bits of wdata are used for the cycle registers.

FSM (encoding IDLE=0, SETTLE=1, ACTIVE=2, SLEEP=3):
- IDLE: pd=1, rx_en=0. Go to SETTLE on the cycle after EN reads 1.
- SETTLE: pd=0, rx_en=0. Lasts max(SETTLE_CYC,1) cycles, then ACTIVE.
- ACTIVE: pd=0, rx_en=1. Lasts max(ON_CYC,1) cycles. On exit: WIN_CNT++, irq set. If ONESHOT=1, EN clears and next state is IDLE; otherwise next state is SLEEP.
- SLEEP: pd=1, rx_en=0. Lasts max(OFF_CYC,1) cycles, then SETTLE.
- pd and rx_en are registered and decoded from the next state, so they change on the same edge as the state.
- Counter is loaded with max(N,1)-1 on state entry and decrements to 0. Register writes made mid-window take effect at the next state entry.

Boundary cases:
- EN cleared in any state: IDLE on the next edge, pd=1, no irq, WIN_CNT unchanged.
- EN set while already running: no effect.
- IRQ_CLR and an irq set event in the same cycle: set wins, irq stays 1.
- Reset mid-window: immediate pd=1, IDLE.
- Window counter wrap: WIN_CNT rolls over silently.

Optional Feature:
LIMITER_SCHED_WAKE_EN
- Defined: ext_wake port exists. ext_wake=1 in SLEEP forces SETTLE on the next edge, abandoning the remaining OFF count. ext_wake is ignored in other states and is synchronous to clk.
- Undefined: port absent; SLEEP always runs its full OFF_CYC.

Decomposition:
- Shared header: register address constants LIMITER_SCHED_CTRL, _SETTLE, _ON, _OFF, _STATUS, _WIN_CNT; CTRL bit indices; state encoding constants, shared with the firmware driver header.
- Sub-module limiter_sched_timer: CNT_W loadable down-counter with load value, load strobe, and a done output at zero. The FSM instantiates one.

Test Plan:
- Reset only -> pd=1, rx_en=0, irq=0, STATUS=0, WIN_CNT=0.
- SETTLE=3, ON=5, OFF=4, EN=1 -> pd low 8 cycles with rx_en high during the last 5; pd high 4 cycles; repeats; WIN_CNT=2 after 2 periods; irq high after first window.
- ONESHOT=1, SETTLE=0, ON=2 -> 1 settle cycle, 2 rx_en cycles, then IDLE; EN reads 0; WIN_CNT=1.
- Clear EN at cycle 2 of ACTIVE (ON=10) -> pd=1 next edge, no irq, WIN_CNT unchanged.
- Write IRQ_CLR in the same cycle the window ends -> irq remains 1; a second IRQ_CLR clears it.
- With LIMITER_SCHED_WAKE_EN, OFF=100, pulse ext_wake at SLEEP cycle 3 -> SETTLE next edge, pd=0.
